decoder_share_arbiter: RTL and testbench
========================================

Name: decoder_share_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 7-bit combinational decoder instance (decoder_proj_formal style, io_in[6:0]) among NREQ requesters.
- Grants one requester at a time, drives its code onto the decoder input, and holds it for a settle window.
- Captures the decoder output and returns it to the winner, tagged with the requester ID, over a valid/ready response channel.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CODE_W, 7, decoder input width.
- OUT_W, 16, decoder output width captured on dec_out.
- SETTLE, 2, cycles dec_in is held before capture (>=1).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request. Must stay high with req_code stable until its req_ready is seen.
- req_code  input  NREQ*CODE_W  packed codes; requester i uses bits [i*CODE_W +: CODE_W].
- req_ready  output  NREQ  one-hot grant/accept, combinational, only in IDLE.
- dec_in  output  CODE_W  registered drive to the decoder io_in.
- dec_out  input  OUT_W  decoder result.
- rsp_valid  output  1  response valid.
- rsp_id  output  clog2(NREQ)  index of the served requester.
- rsp_data  output  OUT_W  captured dec_out.
- rsp_ready  input  1  response consumer ready.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (async, immediate), every output and register cleared:
  - state = IDLE, rr_ptr = 0, cnt = 0.
  - dec_in = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - req_ready = 0, busy = 0.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - Winner g = first index with req_valid set, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[g] = 1 combinationally. All other req_ready bits are 0.
  - On the clock edge: dec_in <= req_code[g], rsp_id <= g, cnt <= SETTLE-1, rr_ptr <= (g+1) mod NREQ, state -> SETTLE.
  - With no req_valid set, the FSM stays in IDLE and dec_in holds its last value.
- SETTLE:
  - If cnt != 0: cnt <= cnt-1.
  - If cnt == 0: rsp_data <= dec_out, rsp_valid <= 1, state -> RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_data and dec_in are held.
  - When rsp_valid & rsp_ready: rsp_valid <= 0, state -> IDLE.
  - While rsp_ready is low, the block stalls indefinitely and grants nothing.
- Latency: rsp_valid rises exactly SETTLE+1 cycles after the grant edge.
- Throughput with rsp_ready tied high: one transaction per SETTLE+2 cycles.
- Fairness: after requester k is served, k has the lowest priority for the next grant. With all requesters active, the grant order is strictly cyclic.
- Boundary conditions:
  - rr_ptr wraps from NREQ-1 to 0.
  - A request that drops before its grant is simply not served; no error is raised.
  - A new req_valid arriving during SETTLE or RESP waits until IDLE.
  - Reset asserted in SETTLE or RESP aborts the transaction: rsp_valid drops immediately and no response is ever issued for it.
  - rsp_data is written only on capture, so it is stable throughout RESP.

Optional Feature:
- Macro: DECODER_SHARE_ARBITER_STATS_EN.
- When defined:
  - Adds output grant_cnt [NREQ*16-1:0], one 16-bit counter per requester.
  - Counter i increments on each grant to i and saturates at 16'hFFFF (no wrap).
  - All counters are cleared by reset.
- When undefined: the port and counters do not exist, and the behaviour is otherwise identical.

Test Plan:
- Reset check: assert reset mid-cycle at any time -> all outputs read 0 asynchronously. Deassert with no requests -> busy=0, dec_in=0.
- Single request, SETTLE=2:
  - Stimulus: req_valid=4'b0100, code 7'b1011111, rsp_ready=1, decoder model returns 16'hA55A.
  - Expect: req_ready=4'b0100 in the grant cycle, dec_in=7'b1011111 from the next cycle.
  - Expect: rsp_valid 3 cycles after grant with rsp_id=2, rsp_data=16'hA55A.
- Round-robin: req_valid=4'b1111 held, rsp_ready=1 -> grants in order 0,1,2,3,0. Each response is exactly 4 cycles after the previous one.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid, rsp_id, rsp_data and dec_in are constant, and no req_ready is asserted. Raise rsp_ready -> IDLE next cycle.
- Mid-operation reset: assert reset during SETTLE for requester 1 -> rsp_valid never asserts for it. After release, req_valid=4'b0010 is served with rsp_id=1, and rr_ptr starts from 0.
- Stats (macro on): grant requester 3 sixty-six thousand times with the counter preloaded near the top (force) -> grant_cnt[63:48] saturates at 16'hFFFF.

Source files
------------

// File: rtl/decoder_share_arbiter.sv
// decoder_share_arbiter
//   Round-robin arbiter/sequencer that time-shares one combinational decoder
//   among NREQ requesters. A winner's code is registered onto dec_in. It is held
//   for SETTLE cycles, and then dec_out is captured. The result is returned to
//   the requester over a valid/ready response channel, tagged with its index.
//
// Ports
//   clock, reset           rising-edge clock, asynchronous active-high reset
//   req_valid[NREQ]        per-requester request (held until req_ready seen)
//   req_code[NREQ*CODE_W]  packed request codes, requester i at [i*CODE_W +: CODE_W]
//   req_ready[NREQ]        one-hot accept, combinational, only while idle
//   dec_in[CODE_W]         registered drive to the shared decoder input
//   dec_out[OUT_W]         shared decoder result
//   rsp_valid/rsp_ready    response handshake
//   rsp_id, rsp_data       served requester index and captured decoder result
//   busy                   high whenever a transaction is in progress
//
// Optional feature (macro DECODER_SHARE_ARBITER_STATS_EN)
//   Adds grant_cnt[NREQ*16], one saturating 16-bit grant counter per requester.
module decoder_share_arbiter #(
    parameter int NREQ   = 4,
    parameter int CODE_W = 7,
    parameter int OUT_W  = 16,
    parameter int SETTLE = 2,
    localparam int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*CODE_W-1:0] req_code,
    output logic [NREQ-1:0]        req_ready,
    output logic [CODE_W-1:0]      dec_in,
    input  logic [OUT_W-1:0]       dec_out,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [OUT_W-1:0]       rsp_data,
    input  logic                   rsp_ready,
    output logic                   busy
`ifdef DECODER_SHARE_ARBITER_STATS_EN
    ,
    output logic [NREQ*16-1:0]     grant_cnt
`endif
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] dec_in_q, dec_in_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [OUT_W-1:0]  rsp_data_q, rsp_data_d;

    logic              found;
    logic [ID_W-1:0]   win;
    logic [ID_W:0]     probe;
    logic              grant_fire;

    // Rotating priority search: probe indices rr_ptr, rr_ptr+1, ... modulo
    // NREQ. One extra bit in probe keeps the sum from overflowing before the wrap.
    always_comb begin
        found = 1'b0;
        win   = '0;
        probe = '0;
        for (int j = 0; j < NREQ; j++) begin
            probe = {1'b0, rr_ptr_q} + (ID_W+1)'(j);
            if (probe >= (ID_W+1)'(NREQ)) begin
                probe = probe - (ID_W+1)'(NREQ);
            end
            if (!found && req_valid[probe[ID_W-1:0]]) begin
                found = 1'b1;
                win   = probe[ID_W-1:0];
            end
        end
    end

    assign grant_fire = (state_q == S_IDLE) && found;

    // Gate the accept with reset so that nothing is granted while reset is asserted.
    assign req_ready = (grant_fire && !reset) ? (NREQ'(1) << win) : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        dec_in_d    = dec_in_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    dec_in_d = req_code[win*CODE_W +: CODE_W];
                    rsp_id_d = win;
                    cnt_d    = CNT_W'(SETTLE - 1);
                    rr_ptr_d = (win == ID_W'(NREQ - 1)) ? '0 : win + ID_W'(1);
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rsp_data_d  = dec_out;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            dec_in_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            dec_in_q    <= dec_in_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign dec_in    = dec_in_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != S_IDLE);

`ifdef DECODER_SHARE_ARBITER_STATS_EN
    logic [NREQ*16-1:0] grant_cnt_q, grant_cnt_d;

    // Saturating per-requester grant counters.
    always_comb begin
        grant_cnt_d = grant_cnt_q;
        if (grant_fire && (grant_cnt_q[win*16 +: 16] != 16'hFFFF)) begin
            grant_cnt_d[win*16 +: 16] = grant_cnt_q[win*16 +: 16] + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_share_arbiter.sv
// Self-checking bench for decoder_share_arbiter (NREQ=4, CODE_W=7, OUT_W=16, SETTLE=2).
module tb_decoder_share_arbiter;
    localparam int NREQ   = 4;
    localparam int CODE_W = 7;
    localparam int OUT_W  = 16;
    localparam int SETTLE = 2;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ*CODE_W-1:0] req_code = '0;
    logic [NREQ-1:0]        req_ready;
    logic [CODE_W-1:0]      dec_in;
    logic [OUT_W-1:0]       dec_out;
    logic                   rsp_valid;
    logic [1:0]             rsp_id;
    logic [OUT_W-1:0]       rsp_data;
    logic                   rsp_ready = 1'b0;
    logic                   busy;
`ifdef DECODER_SHARE_ARBITER_STATS_EN
    logic [NREQ*16-1:0]     grant_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    // Decoder stand-in: one fixed special code, otherwise a simple invertible pattern.
    function automatic logic [15:0] dec_model(input logic [6:0] x);
        if (x == 7'b1011111) return 16'hA55A;
        return {x, ~x, x[1:0]};
    endfunction

    function automatic logic [6:0] code_of(input int i);
        return 7'((i * 29 + 5) % 128);
    endfunction

    assign dec_out = dec_model(dec_in);

    decoder_share_arbiter #(
        .NREQ(NREQ), .CODE_W(CODE_W), .OUT_W(OUT_W), .SETTLE(SETTLE)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
        .dec_in(dec_in), .dec_out(dec_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_ready(rsp_ready), .busy(busy)
`ifdef DECODER_SHARE_ARBITER_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 0);
        chk({tag, "_rsp_id"},    64'(rsp_id),    0);
        chk({tag, "_rsp_data"},  64'(rsp_data),  0);
        chk({tag, "_dec_in"},    64'(dec_in),    0);
        chk({tag, "_req_ready"}, 64'(req_ready), 0);
        chk({tag, "_busy"},      64'(busy),      0);
    endtask

    task automatic set_code(input int i, input logic [6:0] c);
        req_code[i*CODE_W +: CODE_W] = c;
    endtask

    task automatic set_all_codes();
        for (int i = 0; i < NREQ; i++) set_code(i, code_of(i));
    endtask

    // Called at posedge+1; returns at posedge+1 with reset released and the FSM idle.
    task automatic do_reset();
        req_valid = '0;
        rsp_ready = 1'b1;
        reset     = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] rv;
        logic [3:0] exp_rdy;
        logic [1:0] exp_id;
    } vec_t;

    vec_t tbl[7];

    // Scoreboard state for the random phase
    int          rr_m, g_cyc, w, n_ev;
    bit          outst, exp_rv;
    logic [1:0]  e_id;
    logic [15:0] e_data;
    logic [6:0]  last_code, code0;
    logic [3:0]  pend, taken, exp_rdy;
    int          ev_id[5], ev_c[5];
    logic [15:0] ev_d[5];

    initial begin
        // Grant decisions from a freshly reset arbiter (pointer at 0).
        tbl[0] = '{4'b0001, 4'b0001, 2'd0};
        tbl[1] = '{4'b0100, 4'b0100, 2'd2};
        tbl[2] = '{4'b1100, 4'b0100, 2'd2};
        tbl[3] = '{4'b1010, 4'b0010, 2'd1};
        tbl[4] = '{4'b1000, 4'b1000, 2'd3};
        tbl[5] = '{4'b0000, 4'b0000, 2'd0};
        tbl[6] = '{4'b1111, 4'b0001, 2'd0};

        // Reset state, sampled mid-cycle while reset is held.
        #12;
        chk_zero("rst0");
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_rel_busy", 64'(busy), 0);
        chk("rst_rel_dec_in", 64'(dec_in), 0);

        // Table-driven first-grant vectors.
        for (int r = 0; r < 7; r++) begin
            @(posedge clock);
            #1;
            do_reset();
            set_all_codes();
            req_valid = tbl[r].rv;
            @(negedge clock);
            chk("tbl_ready", 64'(req_ready), 64'(tbl[r].exp_rdy));
            @(posedge clock);
            #1;
            req_valid = '0;
            repeat (2) @(negedge clock);
            @(negedge clock);
            chk("tbl_rsp_valid", 64'(rsp_valid), 64'(tbl[r].exp_rdy != 0));
            if (tbl[r].exp_rdy != 0) begin
                chk("tbl_rsp_id", 64'(rsp_id), 64'(tbl[r].exp_id));
                chk("tbl_rsp_data", 64'(rsp_data), 64'(dec_model(code_of(int'(tbl[r].exp_id)))));
            end
        end

        // Single request, code 7'b1011111 -> 16'hA55A, exact latency.
        @(posedge clock);
        #1;
        do_reset();
        set_code(2, 7'b1011111);
        req_valid = 4'b0100;
        @(negedge clock);
        chk("single_ready", 64'(req_ready), 64'(4'b0100));
        chk("single_busy_grant", 64'(busy), 0);
        @(posedge clock);
        #1;
        req_valid = '0;
        @(negedge clock);
        chk("single_dec_in", 64'(dec_in), 64'(7'b1011111));
        chk("single_busy", 64'(busy), 1);
        chk("single_rv_g1", 64'(rsp_valid), 0);
        @(negedge clock);
        chk("single_rv_g2", 64'(rsp_valid), 0);
        @(negedge clock);
        chk("single_rv_g3", 64'(rsp_valid), 1);
        chk("single_id", 64'(rsp_id), 2);
        chk("single_data", 64'(rsp_data), 64'(16'hA55A));
        @(negedge clock);
        chk("single_idle", 64'(busy), 0);
        chk("single_rv_drop", 64'(rsp_valid), 0);

        // Round-robin with all requesters active and the consumer always ready.
        @(posedge clock);
        #1;
        do_reset();
        set_all_codes();
        req_valid = 4'b1111;
        n_ev = 0;
        for (int i = 0; i < 5; i++) begin
            ev_id[i] = -1;
            ev_c[i] = 0;
            ev_d[i] = '0;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (rsp_valid && n_ev < 5) begin
                ev_id[n_ev] = int'(rsp_id);
                ev_c[n_ev]  = c;
                ev_d[n_ev]  = rsp_data;
                n_ev++;
            end
        end
        chk("rr_count", 64'(n_ev), 5);
        for (int k = 0; k < 5; k++) begin
            chk("rr_id", 64'(ev_id[k]), 64'(k % 4));
            chk("rr_data", 64'(ev_d[k]), 64'(dec_model(code_of(k % 4))));
            if (k > 0) chk("rr_gap", 64'(ev_c[k] - ev_c[k-1]), 4);
        end

        // Backpressure: response held for 10 cycles, nothing granted meanwhile.
        @(posedge clock);
        #1;
        do_reset();
        set_all_codes();
        code0 = code_of(0);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        @(negedge clock);
        chk("bp_grant", 64'(req_ready), 64'(4'b0001));
        repeat (3) @(negedge clock);
        for (int k = 0; k < 10; k++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 1);
            chk("bp_rsp_id", 64'(rsp_id), 0);
            chk("bp_rsp_data", 64'(rsp_data), 64'(dec_model(code0)));
            chk("bp_dec_in", 64'(dec_in), 64'(code0));
            chk("bp_req_ready", 64'(req_ready), 0);
            @(negedge clock);
        end
        @(posedge clock);
        #1;
        rsp_ready = 1'b1;
        @(negedge clock);
        chk("bp_last_valid", 64'(rsp_valid), 1);
        @(negedge clock);
        chk("bp_idle_busy", 64'(busy), 0);
        chk("bp_next_grant", 64'(req_ready), 64'(4'b0010));

        // Asynchronous reset while a response is stalled.
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("ar_rsp_valid", 64'(rsp_valid), 1);
        chk("ar_rsp_id", 64'(rsp_id), 1);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk_zero("ar");
        @(posedge clock);
        #1;
        req_valid = '0;
        reset = 1'b0;
        @(negedge clock);
        chk("ar_busy", 64'(busy), 0);
        chk("ar_dec_in", 64'(dec_in), 0);
        chk("ar_rv", 64'(rsp_valid), 0);

        // Reset during SETTLE for requester 1 aborts it.
        @(posedge clock);
        #1;
        do_reset();
        set_code(1, 7'h33);
        req_valid = 4'b0010;
        @(negedge clock);
        chk("mr_grant", 64'(req_ready), 64'(4'b0010));
        @(posedge clock);
        #1;
        req_valid = '0;
        @(negedge clock);
        chk("mr_settle_busy", 64'(busy), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_rv_in_reset", 64'(rsp_valid), 0);
        chk("mr_busy_in_reset", 64'(busy), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk("mr_no_rsp", 64'(rsp_valid), 0);
        end
        @(posedge clock);
        #1;
        req_valid = 4'b0010;
        @(negedge clock);
        chk("mr_regrant", 64'(req_ready), 64'(4'b0010));
        @(posedge clock);
        #1;
        req_valid = '0;
        repeat (2) @(negedge clock);
        @(negedge clock);
        chk("mr_rsp_valid", 64'(rsp_valid), 1);
        chk("mr_rsp_id", 64'(rsp_id), 1);
        chk("mr_rsp_data", 64'(rsp_data), 64'(dec_model(7'h33)));

        // Requests arriving while busy wait; a request that drops before grant is not served.
        @(posedge clock);
        #1;
        do_reset();
        set_all_codes();
        req_valid = 4'b0001;
        @(negedge clock);
        @(posedge clock);
        #1;
        req_valid = 4'b1000;
        @(negedge clock);
        chk("drop_no_grant_busy", 64'(req_ready), 0);
        @(posedge clock);
        #1;
        req_valid = '0;
        @(negedge clock);
        @(negedge clock);
        chk("drop_rsp_valid", 64'(rsp_valid), 1);
        chk("drop_rsp_id", 64'(rsp_id), 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("drop_idle", 64'(busy), 0);
            chk("drop_rdy", 64'(req_ready), 0);
        end

`ifdef DECODER_SHARE_ARBITER_STATS_EN
        // Saturation of requester 3's counter, preloaded near the top.
        @(posedge clock);
        #1;
        do_reset();
        chk("stats_reset", 64'(grant_cnt), 0);
        force dut.grant_cnt_q = {16'hFFFD, 48'h0};
        @(posedge clock);
        #1;
        release dut.grant_cnt_q;
        req_valid = 4'b1000;
        repeat (20) @(posedge clock);
        #1;
        req_valid = '0;
        repeat (6) @(negedge clock);
        chk("stats_sat", 64'(grant_cnt[63:48]), 64'(16'hFFFF));
        chk("stats_others", 64'(grant_cnt[47:0]), 0);
`endif

        // Randomized traffic checked against a transaction-level scoreboard.
        @(posedge clock);
        #1;
        do_reset();
        rr_m = 0;
        outst = 1'b0;
        g_cyc = 0;
        e_id = '0;
        e_data = '0;
        last_code = '0;
        pend = '0;
        taken = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) begin
                @(posedge clock);
                #1;
            end
            pend = pend & ~taken;
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    set_code(i, 7'($urandom_range(0, 127)));
                end
            end
            req_valid = pend;
            rsp_ready = ($urandom_range(0, 2) != 0);
            @(negedge clock);
            exp_rdy = '0;
            w = -1;
            if (!outst) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (w < 0 && req_valid[(rr_m + k) % NREQ]) w = (rr_m + k) % NREQ;
                end
                if (w >= 0) exp_rdy = 4'(1 << w);
            end
            exp_rv = outst && ((cyc - g_cyc) >= SETTLE + 1);
            chk("rnd_req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("rnd_busy", 64'(busy), 64'(outst));
            chk("rnd_dec_in", 64'(dec_in), 64'(last_code));
            chk("rnd_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            if (exp_rv) begin
                chk("rnd_rsp_id", 64'(rsp_id), 64'(e_id));
                chk("rnd_rsp_data", 64'(rsp_data), 64'(e_data));
            end
            taken = req_ready;
            if (!outst && w >= 0) begin
                outst     = 1'b1;
                g_cyc     = cyc;
                e_id      = 2'(w);
                last_code = req_code[w*CODE_W +: CODE_W];
                e_data    = dec_model(last_code);
                rr_m      = (w + 1) % NREQ;
            end else if (exp_rv && rsp_ready) begin
                outst = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
